// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: FWFT read port, sticky overflow/framing flags, RTS_n.
// Optional drop counter port drop_cnt_o is built when UART_RX_FIFO_DROP_CNT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int RTS_THRESH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            wr_data_i,
  input  logic                  wr_valid_i,
  input  logic                  frame_err_i,
  output logic [7:0]            rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  input  logic                  flush_i,
  input  logic                  err_clr_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  overflow_o,
  output logic                  frame_err_o,
  output logic                  rts_n_o
`ifdef UART_RX_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] RTS_LVL = PW'(RTS_THRESH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] wr_ptr_d, rd_ptr_d, level_d;
  logic          empty, full, pop, push, drop;
  logic          overflow_q, frame_err_q, rts_n_q;

  // Read handshake: rd_valid_o means a byte sits at the head; the byte is consumed on a
  // clock edge where rd_valid_o and rd_ready_i are both high. rd_ready_i may toggle freely.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

  // Flush overrides both ports, so a coincident push is neither stored nor a drop.
  assign pop  = !empty && rd_ready_i && !flush_i;
  assign push = wr_valid_i && !flush_i && (!full || pop);
  assign drop = wr_valid_i && !flush_i && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
    level_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rts_n_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rts_n_q  <= (level_d >= RTS_LVL);
      // Set beats clear when both arrive together.
      if (drop)           overflow_q <= 1'b1;
      else if (err_clr_i) overflow_q <= 1'b0;
      if (frame_err_i)    frame_err_q <= 1'b1;
      else if (err_clr_i) frame_err_q <= 1'b0;
    end
  end

  // Storage is deliberately unreset; rd_data_o is masked while empty instead.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q[PW-2:0]] <= wr_data_i;
  end

  assign rd_valid_o  = !empty;
  assign rd_data_o   = empty ? 8'h00 : mem[rd_ptr_q[PW-2:0]];
  assign level_o     = wr_ptr_q - rd_ptr_q;
  assign overflow_o  = overflow_q;
  assign frame_err_o = frame_err_q;
  assign rts_n_o     = rts_n_q;

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      drop_cnt_q <= 8'h00;
    end else if (err_clr_i) begin
      drop_cnt_q <= drop ? 8'h01 : 8'h00;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  // Without the counter, overflow_o is the only indication of a dropped byte.
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand sequences and random traffic
// checked against a queue-based model of the FIFO.
module tb_uart_rx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       wr_valid_i = 1'b0;
  logic       frame_err_i = 1'b0;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       rd_ready_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic [3:0] level_o;
  logic       overflow_o;
  logic       frame_err_o;
  logic       rts_n_o;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_o;
`endif

  uart_rx_fifo #(.DEPTH_LOG2(3), .RTS_THRESH(6)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_data_i   (wr_data_i),
    .wr_valid_i  (wr_valid_i),
    .frame_err_i (frame_err_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .flush_i     (flush_i),
    .err_clr_i   (err_clr_i),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .frame_err_o (frame_err_o),
    .rts_n_o     (rts_n_o)
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    .drop_cnt_o  (drop_cnt_o)
`endif
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // reference model: the FIFO contents as a queue plus the sticky state
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_fe  = 1'b0;
  logic [7:0] m_drop = 8'h00;

  task automatic model_reset();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_fe   = 1'b0;
    m_drop = 8'h00;
  endtask

  task automatic model_step(input logic wv, input logic [7:0] wd, input logic rr,
                            input logic fl, input logic ec, input logic fe);
    logic was_full, did_pop, dropped;
    was_full = (exp_q.size() == 8);
    did_pop  = 1'b0;
    dropped  = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rr && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        did_pop = 1'b1;
      end
      if (wv) begin
        if (!was_full || did_pop) exp_q.push_back(wd);
        else dropped = 1'b1;
      end
    end
    m_ovf = dropped ? 1'b1 : (ec ? 1'b0 : m_ovf);
    m_fe  = fe ? 1'b1 : (ec ? 1'b0 : m_fe);
    if (ec) m_drop = dropped ? 8'h01 : 8'h00;
    else if (dropped && m_drop != 8'hFF) m_drop = m_drop + 8'h01;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".level"},    32'(level_o),     32'(exp_q.size()));
    check({tag, ".valid"},    32'(rd_valid_o),  32'(exp_q.size() > 0));
    check({tag, ".data"},     32'(rd_data_o),   32'(exp_q.size() > 0 ? exp_q[0] : 8'h00));
    check({tag, ".overflow"}, 32'(overflow_o),  32'(m_ovf));
    check({tag, ".frame_err"},32'(frame_err_o), 32'(m_fe));
    check({tag, ".rts_n"},    32'(rts_n_o),     32'(exp_q.size() >= 6));
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check({tag, ".drop_cnt"}, 32'(drop_cnt_o),  32'(m_drop));
`endif
  endtask

  // driver: hold inputs across one rising edge, update the model, sample 1 ns later
  task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr,
                       input logic fl, input logic ec, input logic fe);
    wr_valid_i  = wv;
    wr_data_i   = wd;
    rd_ready_i  = rr;
    flush_i     = fl;
    err_clr_i   = ec;
    frame_err_i = fe;
    @(posedge clk_i);
    model_step(wv, wd, rr, fl, ec, fe);
    #1;
    wr_valid_i  = 1'b0;
    rd_ready_i  = 1'b0;
    flush_i     = 1'b0;
    err_clr_i   = 1'b0;
    frame_err_i = 1'b0;
  endtask

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr, fl, ec, fe;
    logic [3:0] lvl;
    logic       vld;
    logic [7:0] data;
    logic       ovf, feo, rts;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic wv, logic [7:0] wd, logic rr, logic fl, logic ec,
                              logic fe, logic [3:0] lvl, logic vld, logic [7:0] data,
                              logic ovf, logic feo, logic rts);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr; v.fl = fl; v.ec = ec; v.fe = fe;
    v.lvl = lvl; v.vld = vld; v.data = data; v.ovf = ovf; v.feo = feo; v.rts = rts;
    return v;
  endfunction

  initial begin
    //            wv wd    rr fl ec fe   lvl vld data  ovf fe rts
    vt.push_back(mk(1, 8'hA5, 0, 0, 0, 0,  1, 1, 8'hA5, 0, 0, 0));
    vt.push_back(mk(1, 8'h11, 0, 0, 0, 0,  2, 1, 8'hA5, 0, 0, 0));
    vt.push_back(mk(1, 8'h22, 0, 0, 0, 0,  3, 1, 8'hA5, 0, 0, 0));
    vt.push_back(mk(1, 8'h33, 0, 0, 0, 0,  4, 1, 8'hA5, 0, 0, 0));
    vt.push_back(mk(1, 8'h44, 0, 0, 0, 0,  5, 1, 8'hA5, 0, 0, 0));
    vt.push_back(mk(1, 8'h55, 0, 0, 0, 0,  6, 1, 8'hA5, 0, 0, 1));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 0,  5, 1, 8'h11, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 1,  5, 1, 8'h11, 0, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0,  5, 1, 8'h11, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 0,  4, 1, 8'h22, 0, 0, 0));
    vt.push_back(mk(1, 8'h66, 0, 1, 0, 0,  0, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(1, 8'(i), 0, 0, 0, 0, 4'(i + 1), 1, 8'h00, 0, 0, (i >= 5)));
    vt.push_back(mk(1, 8'hFF, 0, 0, 0, 0,  8, 1, 8'h00, 1, 0, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0,  8, 1, 8'h00, 0, 0, 1));
    vt.push_back(mk(1, 8'hAA, 1, 0, 0, 0,  8, 1, 8'h01, 0, 0, 1));
    vt.push_back(mk(1, 8'hBB, 0, 0, 0, 0,  8, 1, 8'h01, 1, 0, 1));
    vt.push_back(mk(1, 8'hCC, 0, 1, 0, 0,  0, 0, 8'h00, 1, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'h00, 0, 0, 0));

    model_reset();
    repeat (3) @(negedge clk_i);
    check_model("reset");
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // directed table
    foreach (vt[i]) begin
      cycle(vt[i].wv, vt[i].wd, vt[i].rr, vt[i].fl, vt[i].ec, vt[i].fe);
      check($sformatf("vec%0d.level", i),     32'(level_o),     32'(vt[i].lvl));
      check($sformatf("vec%0d.valid", i),     32'(rd_valid_o),  32'(vt[i].vld));
      check($sformatf("vec%0d.data", i),      32'(rd_data_o),   32'(vt[i].data));
      check($sformatf("vec%0d.overflow", i),  32'(overflow_o),  32'(vt[i].ovf));
      check($sformatf("vec%0d.frame_err", i), 32'(frame_err_o), 32'(vt[i].feo));
      check($sformatf("vec%0d.rts_n", i),     32'(rts_n_o),     32'(vt[i].rts));
`ifdef UART_RX_FIFO_DROP_CNT_EN
      check($sformatf("vec%0d.drop_cnt", i),  32'(drop_cnt_o),  32'(m_drop));
`endif
    end

    // three fill / push-while-full-with-pop / drain passes to exercise pointer wrap
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) begin
        cycle(1, 8'($urandom_range(0, 255)), 0, 0, 0, 0);
        check_model($sformatf("wrap%0d.fill", p));
      end
      cycle(1, 8'($urandom_range(0, 255)), 1, 0, 0, 0);
      check_model($sformatf("wrap%0d.full_pushpop", p));
      for (int i = 0; i < 9; i++) begin
        cycle(0, 8'h00, 1, 0, 0, 0);
        check_model($sformatf("wrap%0d.drain", p));
      end
    end

    // empty with push and rd_ready high: push only
    cycle(1, 8'h5A, 1, 0, 0, 0);
    check_model("empty_push_ready");
    cycle(0, 8'h00, 1, 0, 0, 0);
    check_model("empty_push_ready.pop");

    // async reset with 3 entries and overflow set
    for (int i = 0; i < 9; i++) cycle(1, 8'(8'h30 + i), 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0, 0, 0);
    check_model("pre_reset");
    #3;
    rst_i = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    #2;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_model("after_reset");

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 9) < 6), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 5));
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
